// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a row-addressed pixel array: erase, expose, then convert
// and hand off each row downstream with a per-row row_done timeout.
module pixel_array_ctrl #(
    parameter int ROWS         = 3,
    parameter int COLUMNS      = 3,
    parameter int WIDTH        = 2,
    parameter int RESOLUTION   = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   expose_time,
    output logic                          ERASE,
    output logic                          EXPOSE,
    output logic                          enable,
    output logic [WIDTH-1:0]              decoder_select,
    input  logic                          row_done,
    input  logic [COLUMNS*RESOLUTION-1:0] adc_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLUMNS*RESOLUTION-1:0] out_data,
    output logic [WIDTH-1:0]              out_row,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_err,
    output logic [2:0]                    state_dbg
);

    // Handshake: a row transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and out_data/out_row never change until that edge.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ERASE_PH  = 3'd1,
        EXPOSE_PH = 3'd2,
        CONVERT   = 3'd3,
        OUTPUT    = 3'd4,
        SETTLE    = 3'd5
    } state_t;

    localparam int CNT_MAX0 = (ERASE_CYCLES > TIMEOUT) ? ERASE_CYCLES : TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > 65535) ? CNT_MAX0 : 65535;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [WIDTH-1:0] LAST_ROW   = WIDTH'(ROWS - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      exp_len;

    logic erase_done;
    logic expose_done;
    logic tmo_hit;
    logic accept;
    logic last_row;

    assign erase_done  = (cnt == ERASE_LAST);
    assign expose_done = (cnt == CNT_W'(exp_len - 16'd1));
    // >= rather than == so a SETTLE that ends on the last allowed cycle still times out in CONVERT
    assign tmo_hit     = (cnt >= TMO_LAST);
    assign accept      = (state == OUTPUT) && out_ready;
    assign last_row    = (decoder_select == LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = ERASE_PH;
            ERASE_PH:  if (erase_done) state_nxt = EXPOSE_PH;
            EXPOSE_PH: if (expose_done) state_nxt = CONVERT;
            CONVERT:   if (row_done || tmo_hit) state_nxt = OUTPUT;
            OUTPUT:    if (accept) state_nxt = last_row ? IDLE : SETTLE;
            SETTLE: begin
                if (!row_done) begin
                    state_nxt = CONVERT;
                end else if (tmo_hit) begin
                    state_nxt = OUTPUT;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ERASE     = (state == ERASE_PH);
        EXPOSE    = (state == EXPOSE_PH);
        enable    = (state == CONVERT);
        out_valid = (state == OUTPUT);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            exp_len        <= '0;
            decoder_select <= '0;
            out_data       <= '0;
            out_row        <= '0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_len        <= (expose_time == 16'd0) ? 16'd1 : expose_time;
                        decoder_select <= '0;
                        timeout_err    <= 1'b0;
                        cnt            <= '0;
                    end
                end
                ERASE_PH:  cnt <= erase_done ? '0 : cnt + 1'b1;
                EXPOSE_PH: cnt <= expose_done ? '0 : cnt + 1'b1;
                CONVERT: begin
                    if (row_done) begin
                        out_data <= adc_data;
                        out_row  <= decoder_select;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        out_data    <= '0;
                        out_row     <= decoder_select;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (accept) begin
                        cnt <= '0;
                        if (last_row) begin
                            frame_done <= 1'b1;
                        end else begin
                            decoder_select <= decoder_select + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (row_done && tmo_hit) begin
                        timeout_err <= 1'b1;
                        out_data    <= '0;
                        out_row     <= decoder_select;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: a small array model answers enable with
// row_done after 4 cycles; a negedge monitor records strobes and accepted rows.
module tb_pixel_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] expose_time;
    logic        ERASE, EXPOSE, enable;
    logic [1:0]  decoder_select;
    logic        row_done;
    logic [23:0] adc_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [1:0]  out_row;
    logic        busy, frame_done, timeout_err;
    logic [2:0]  state_dbg;

    pixel_array_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .expose_time    (expose_time),
        .ERASE          (ERASE),
        .EXPOSE         (EXPOSE),
        .enable         (enable),
        .decoder_select (decoder_select),
        .row_done       (row_done),
        .adc_data       (adc_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Array model: row_done rises on the 4th enable cycle, drops when enable drops
    bit model_on = 1'b0;
    int ecnt     = 0;
    always @(negedge clk) begin
        if (model_on && enable) begin
            ecnt++;
            row_done = (ecnt >= 4);
        end else begin
            ecnt     = 0;
            row_done = 1'b0;
        end
    end

    // Monitor: only this block writes these
    int          erase_total   = 0;
    int          expose_total  = 0;
    int          overlap_total = 0;
    int          fd_total      = 0;
    int          acc_total     = 0;
    int          en_runs       = 0;
    int          en_run        = 0;
    bit          en_prev       = 1'b0;
    logic [25:0] obs_mem    [0:255];
    int          en_len_mem [0:255];
    logic [1:0]  sel_mem    [0:255];

    always @(negedge clk) begin
        if (ERASE === 1'b1) erase_total++;
        if (EXPOSE === 1'b1) expose_total++;
        if (ERASE === 1'b1 && EXPOSE === 1'b1) overlap_total++;
        if (frame_done === 1'b1) fd_total++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_mem[acc_total[7:0]] = {out_row, out_data};
            acc_total++;
        end
        if (enable === 1'b1) begin
            if (!en_prev) sel_mem[en_runs[7:0]] = decoder_select;
            en_run++;
            en_prev = 1'b1;
        end else if (en_prev) begin
            en_len_mem[en_runs[7:0]] = en_run;
            en_runs++;
            en_run  = 0;
            en_prev = 1'b0;
        end
    end

    logic [25:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] et);
        expose_time = et;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid_wait"}, out_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle_wait"}, busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {ERASE, EXPOSE, enable, out_valid, busy, frame_done, timeout_err}, 0);
        check({tag, "_sel"}, decoder_select, 0);
        check({tag, "_row"}, out_row, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    task automatic frame_check(input string tag, input logic [15:0] et, input int exp_expose,
                               input int en0, input int en1, input logic [23:0] data,
                               input bit tmo, input bit stall, input bit mid_start);
        int          b_erase, b_expose, b_ovl, b_fd, b_acc, b_run;
        logic [23:0] row_data;
        logic [25:0] exp_e;
        b_erase  = erase_total;
        b_expose = expose_total;
        b_ovl    = overlap_total;
        b_fd     = fd_total;
        b_acc    = acc_total;
        b_run    = en_runs;
        row_data = tmo ? 24'h0 : data;
        adc_data = data;
        out_ready = !stall;
        for (int r = 0; r < 3; r++) exp_q.push_back({r[1:0], row_data});

        start_frame(et);
        check({tag, "_busy_on_start"}, busy, 1);
        check({tag, "_tmo_cleared"}, timeout_err, 0);

        wait_valid(tag, 400);
        check({tag, "_tmo_flag"}, timeout_err, tmo);
        if (stall) begin
            for (int i = 0; i < 7; i++) begin
                tick();
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_enable"}, enable, 0);
                check({tag, "_stall_data"}, out_data, row_data);
                check({tag, "_stall_row"}, out_row, 0);
                check({tag, "_stall_sel"}, decoder_select, 0);
            end
            out_ready = 1'b1;
        end
        if (mid_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end

        wait_idle(tag, 3000);
        tick();
        check({tag, "_frame_done_low"}, frame_done, 0);
        tick();

        check({tag, "_erase_cycles"}, erase_total - b_erase, 5);
        check({tag, "_expose_cycles"}, expose_total - b_expose, exp_expose);
        check({tag, "_overlap"}, overlap_total - b_ovl, 0);
        check({tag, "_frame_done_pulses"}, fd_total - b_fd, 1);
        check({tag, "_rows_out"}, acc_total - b_acc, 3);
        check({tag, "_en_len0"}, en_len_mem[b_run[7:0]], en0);
        check({tag, "_en_len1"}, en_len_mem[8'(b_run + 1)], en1);
        check({tag, "_en_sel0"}, sel_mem[b_run[7:0]], 0);
        check({tag, "_en_sel2"}, sel_mem[8'(b_run + 2)], 2);
        for (int r = 0; r < 3; r++) begin
            exp_e = exp_q.pop_front();
            check({tag, "_sb_row"}, obs_mem[8'(b_acc + r)], exp_e);
        end
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        expose_time = 16'd0;
        adc_data    = 24'h0;
        out_ready   = 1'b0;
        row_done    = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Nominal frame: 5 erase, 10 expose, rows answered after 4 enable cycles
        model_on = 1'b1;
        frame_check("nominal", 16'd10, 10, 4, 4, 24'h112233, 1'b0, 1'b0, 1'b0);

        // Downstream stall of 7 cycles on row 0
        frame_check("stall", 16'd10, 10, 4, 4, 24'h112233, 1'b0, 1'b1, 1'b0);

        // No row_done at all: row 0 waits 255 CONVERT cycles, later rows lose one to SETTLE
        model_on = 1'b0;
        frame_check("timeout", 16'd10, 10, 255, 254, 24'h112233, 1'b1, 1'b0, 1'b0);

        // Zero exposure counts as one cycle; a start mid-frame changes nothing
        model_on = 1'b1;
        frame_check("expose0", 16'd0, 1, 4, 4, 24'h0F1E2D, 1'b0, 1'b0, 1'b1);

        // Reset during exposure
        out_ready = 1'b1;
        start_frame(16'd10);
        for (int i = 0; i < 20 && EXPOSE !== 1'b1; i++) tick();
        check("rst_exp_in_expose", EXPOSE, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rst_exp");

        // Reset while a row is waiting in OUTPUT
        out_ready = 1'b0;
        adc_data  = 24'hA5C30F;
        start_frame(16'd3);
        wait_valid("rst_out", 100);
        check("rst_out_data_before", out_data, 24'hA5C30F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rst_out");

        // Reset wins over start on the same edge
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", busy, 0);
        tick();
        check("rst_prio_stay_idle", busy, 0);

        frame_check("after_reset", 16'd7, 7, 4, 4, 24'hA5C30F, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
